serial_adder_24bit: RTL
=======================

SERIAL_ADDER_24BIT -- requirements
Module: serial_adder_24bit

Interface
REQ-001 Parameter WIDTH, default 24: operand and sum width in bits; all widths below refer to it.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 a  input  WIDTH  operand A; sampled only on an accepted start.
REQ-006 b  input  WIDTH  operand B; sampled only on an accepted start.
REQ-007 carry_in  input  1  carry into bit 0; sampled only on an accepted start.
REQ-008 busy  output  1  high while bits are being processed.
REQ-009 done  output  1  one-cycle pulse marking sum/carry_out newly valid.
REQ-010 sum  output  WIDTH  registered result, held until next result.
REQ-011 carry_out  output  1  registered carry out of bit WIDTH-1, held with sum.

Function
REQ-012 Block SHALL compute {carry_out, sum} = a + b + carry_in (WIDTH+1-bit result), bit-serially, one full-adder step per clock, LSB first.
REQ-013 FSM states SHALL be IDLE, RUN, DONE; encoding implementer's choice.
REQ-014 IDLE: start=1 SHALL capture a, b, carry_in into internal shift/carry registers, clear bit counter to 0, go to RUN; start=0 stays IDLE.
REQ-015 RUN: each edge SHALL add operand bit [counter] plus carry register, store the sum bit at position [counter] of the result shift register, update carry register, increment counter.
REQ-016 RUN: on the edge processing bit WIDTH-1, the SHALL-completed result and final carry SHALL load into sum/carry_out, and state goes to DONE.
REQ-017 Latency: start sampled at edge 0 -> sum/carry_out valid and done=1 after edge WIDTH (24 by default), i.e. exactly WIDTH cycles.
REQ-018 DONE lasts exactly one cycle; done=1 only in DONE; next edge goes to IDLE, or, if start=1, captures new operands and goes directly to RUN (back-to-back, no idle cycle).
REQ-019 busy SHALL be 1 in RUN only; 0 in IDLE and DONE.
REQ-020 start asserted during RUN SHALL be ignored; operands, counter and outputs unaffected.
REQ-021 Changes on a, b, carry_in after capture SHALL not affect the in-flight result.
REQ-022 sum/carry_out SHALL change only on entry to DONE; stable in all other cycles, including throughout a subsequent RUN.
REQ-023 Counter SHALL be ceil(log2(WIDTH)) bits minimum; no wrap occurs since RUN exits at WIDTH-1.
REQ-024 Carry out of bit WIDTH-1 SHALL go only to carry_out; never wraps into bit 0.

Reset
REQ-025 rst_n=0 SHALL immediately (asynchronously) force state IDLE, busy=0, done=0, sum=0, carry_out=0, counter=0, internal operand/carry registers=0.
REQ-026 Reset during RUN or DONE SHALL abort the operation with no done pulse; after rst_n rises, block waits in IDLE for a new start.
REQ-027 rst_n deassertion SHALL take effect at the next rising clk; start sampled at that edge is accepted.

Verification
REQ-028 a=000001, b=000001, carry_in=0, start 1 cycle -> busy 24 cycles, done pulse once, sum=000002, carry_out=0.
REQ-029 a=FFFFFF, b=000001, carry_in=0 -> sum=000000, carry_out=1; a=7FFFFF, b=000001, carry_in=1 -> sum=800001, carry_out=0.
REQ-030 Back-to-back: start held high through DONE with a=FFFFFF, b=FFFFFF, carry_in=1 -> second done exactly 25 cycles after first start edge +24, sum=FFFFFF, carry_out=1; previous sum stable during second RUN.
REQ-031 start pulsed and a/b changed mid-RUN -> ignored; result matches operands captured at first start; done exactly 24 cycles after capture.
REQ-032 rst_n pulsed low at RUN bit 10 -> outputs zero immediately, no done pulse; new start after release yields correct result with normal latency.
REQ-033 Random: 1000 random a, b, carry_in with random start gaps -> every {carry_out,sum} equals reference a+b+carry_in; exactly one done per accepted start.

Source files
------------

// File: rtl/serial_adder_24bit.sv
// serial_adder_24bit: bit-serial adder producing {carry_out, sum} = a + b + carry_in.
// One full-adder step per clock, LSB first; a result appears WIDTH cycles after start.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : begin an addition (accepted in IDLE or DONE)
//   a, b, carry_in  : operands, captured only on an accepted start
//   busy            : high while bits are being processed
//   done            : one-cycle pulse when sum/carry_out are newly valid
//   sum, carry_out  : registered result, held until the next result
module serial_adder_24bit #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int unsigned     CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             bit_a;
  logic             bit_b;
  logic             bit_s;
  logic             bit_c;
  logic             last;
  logic             capture;

  // Full-adder step on the bit selected by the counter.
  always_comb begin
    bit_a         = a_reg[cnt];
    bit_b         = b_reg[cnt];
    bit_s         = bit_a ^ bit_b ^ carry;
    bit_c         = (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);
    res_next      = res;
    res_next[cnt] = bit_s;
    last          = (cnt == LAST);
    capture       = start && (state != RUN);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, serial accumulation, result load on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (capture) begin
      a_reg <= a;
      b_reg <= b;
      carry <= carry_in;
      res   <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      res   <= res_next;
      carry <= bit_c;
      cnt   <= cnt + CW'(1);
      if (last) begin
        // Final carry goes only to carry_out; it never re-enters bit 0.
        sum       <= res_next;
        carry_out <= bit_c;
      end
    end
  end

endmodule
